vga_bus_responder: RTL and testbench
====================================

VGA_BUS_RESPONDER -- requirements
Module: vga_bus_responder

Interface
REQ-001 The block SHALL be a bus slave serving pixel-word read requests from the VGA bus master, fetching each word through a synchronous memory port.
REQ-002 Parameter ADDR_W SHALL default to 24 and set the word-address width.
REQ-003 Parameter TIMEOUT SHALL default to 16 and set the fetch timeout in clock cycles.
REQ-004 Port clk25MHz SHALL be an input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port bus_req SHALL be an input, 1 bit: master read request, level-held under a 4-phase handshake.
REQ-007 Port bus_addr SHALL be an input, ADDR_W bits: requested word address.
REQ-008 Port bus_out SHALL be an output, 32 bits: read data driven to the master's bus_in.
REQ-009 Port bus_master_ack SHALL be an output, 1 bit: data-valid acknowledge to the master.
REQ-010 Port mem_rd SHALL be an output, 1 bit: one-cycle memory read strobe.
REQ-011 Port mem_addr SHALL be an output, ADDR_W bits: memory word address.
REQ-012 Port mem_rdata SHALL be an input, 32 bits: memory read data.
REQ-013 Port mem_valid SHALL be an input, 1 bit: mem_rdata is valid this cycle.
REQ-014 Port busy SHALL be an output, 1 bit: high in any state other than IDLE.
REQ-015 Port timeout_err SHALL be an output, 1 bit: sticky fetch-timeout flag.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, FETCH, ACK and ABORT, and every output SHALL be registered.
REQ-017 In IDLE with bus_req=1, the next edge SHALL latch bus_addr into mem_addr, assert mem_rd for exactly one cycle, and enter FETCH.
REQ-018 In FETCH, the first edge sampling mem_valid=1 SHALL latch mem_rdata into bus_out, assert bus_master_ack and enter ACK; mem_valid in any other state SHALL be ignored.
REQ-019 Minimum latency SHALL be 2 edges from bus_req high to bus_master_ack high, when mem_valid is returned in the cycle after mem_rd.
REQ-020 In ACK, bus_master_ack and bus_out SHALL hold until bus_req is sampled 0; the next edge SHALL deassert bus_master_ack and enter IDLE.
REQ-021 Changes on bus_addr while in FETCH or ACK SHALL be ignored.
REQ-022 A new request SHALL NOT be accepted until one IDLE cycle with bus_master_ack=0 has elapsed.
REQ-023 If bus_req drops in FETCH, the FSM SHALL enter ABORT, wait for mem_valid, discard the data without asserting ack or updating bus_out, then return to IDLE.
REQ-024 bus_out SHALL retain the last delivered word between transactions.
REQ-025 mem_addr SHALL be a plain latch of bus_addr, with no increment and no wrap logic.

Reset
REQ-026 Asserting reset low SHALL immediately force state=IDLE and bus_out, bus_master_ack, mem_rd, mem_addr, busy, timeout_err and the timeout counter to 0, including mid-transaction.
REQ-027 After reset deasserts, the first request SHALL be accepted at the first rising edge where bus_req=1.

Configuration
REQ-028 With macro VGA_RESP_TIMEOUT_EN defined, a cycle counter SHALL run in FETCH and ABORT.
REQ-029 With VGA_RESP_TIMEOUT_EN defined, TIMEOUT cycles without mem_valid in FETCH SHALL drive bus_out=32'hDEADBEEF, assert bus_master_ack, enter ACK and set timeout_err; in ABORT, a timeout SHALL return the FSM to IDLE and set timeout_err.
REQ-030 Once set, timeout_err SHALL clear only on reset.
REQ-031 Without VGA_RESP_TIMEOUT_EN, no counter SHALL exist, FETCH and ABORT SHALL wait indefinitely, and timeout_err SHALL be constant 0.

Verification
REQ-032 Reset low, then bus_req=1 with bus_addr=24'h000100 -> mem_rd pulses for 1 cycle with mem_addr=24'h000100.
REQ-033 mem_valid=1 with mem_rdata=32'h0000ABCD the cycle after mem_rd -> bus_master_ack=1 and bus_out=32'h0000ABCD two edges after bus_req rose; ack holds until bus_req=0, then falls one edge later.
REQ-034 bus_req dropped while mem_valid is delayed 5 cycles, then mem_valid returns with mem_rdata=32'hFFFF5432 -> bus_master_ack is never asserted and bus_out keeps 32'h0000ABCD.
REQ-035 reset driven low while in ACK -> bus_master_ack=0, bus_out=0 and busy=0 immediately, without waiting for a clock edge.
REQ-036 With VGA_RESP_TIMEOUT_EN and TIMEOUT=16, no mem_valid is returned -> 16 cycles after entering FETCH bus_out=32'hDEADBEEF, ack=1 and timeout_err=1, and timeout_err stays 1 after the handshake completes.
REQ-037 Two back-to-back requests to addresses 24'h000001 and 24'h000002 -> two distinct mem_rd pulses, separated by at least one IDLE cycle with ack=0.

Source files
------------

// File: rtl/vga_bus_responder.sv
// Pixel-word read responder: accepts 4-phase bus requests and fetches each word from a synchronous memory port.
// Optional fetch timeout is enabled by defining VGA_RESP_TIMEOUT_EN.
module vga_bus_responder #(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 16
) (
    input  logic              clk25MHz,
    input  logic              reset,
    input  logic              bus_req,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_out,
    output logic              bus_master_ack,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_valid,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ACK   = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_bus_out, w_bus_out_nxt;
    logic              r_ack, w_ack_nxt;
    logic              r_mem_rd, w_mem_rd_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic              r_busy, w_busy_nxt;
    logic              w_expired;
    logic              w_cnt_run;
    logic              w_terr_set;

    always_ff @(posedge clk25MHz or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // mem_valid takes priority over a simultaneous drop of bus_req in FETCH.
    always_comb begin
        w_state_nxt    = r_state;
        w_bus_out_nxt  = r_bus_out;
        w_ack_nxt      = r_ack;
        w_mem_rd_nxt   = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_cnt_run      = 1'b0;
        w_terr_set     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus_req) begin
                    w_mem_addr_nxt = bus_addr;
                    w_mem_rd_nxt   = 1'b1;
                    w_state_nxt    = FETCH;
                end
            end
            FETCH: begin
                if (mem_valid) begin
                    w_bus_out_nxt = mem_rdata;
                    w_ack_nxt     = 1'b1;
                    w_state_nxt   = ACK;
                end else if (w_expired) begin
                    w_bus_out_nxt = 32'hDEADBEEF;
                    w_ack_nxt     = 1'b1;
                    w_terr_set    = 1'b1;
                    w_state_nxt   = ACK;
                end else begin
                    w_cnt_run = 1'b1;
                    if (!bus_req) begin
                        w_state_nxt = ABORT;
                    end
                end
            end
            ACK: begin
                if (!bus_req) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            ABORT: begin
                if (mem_valid) begin
                    w_state_nxt = IDLE;
                end else if (w_expired) begin
                    w_terr_set  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_run = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk25MHz or negedge reset) begin
        if (!reset) begin
            r_bus_out  <= '0;
            r_ack      <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_bus_out  <= w_bus_out_nxt;
            r_ack      <= w_ack_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

`ifdef VGA_RESP_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;

    // The count spans FETCH and any following ABORT, measured from FETCH entry.
    assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk25MHz or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_run ? r_cnt + 1'b1 : '0;
            if (w_terr_set) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_expired        = 1'b0;
    assign w_unused_timeout = w_cnt_run | w_terr_set;
    assign timeout_err      = 1'b0;
`endif

    assign bus_out        = r_bus_out;
    assign bus_master_ack = r_ack;
    assign mem_rd         = r_mem_rd;
    assign mem_addr       = r_mem_addr;
    assign busy           = r_busy;

endmodule

// File: tb/tb_vga_bus_responder.sv
// Self-checking bench for vga_bus_responder: directed scenarios plus randomized transactions
// against a transaction-level model (last delivered word, sticky timeout flag).
module tb_vga_bus_responder;

    localparam int ADDR_W  = 24;
    localparam int TIMEOUT = 16;

    logic              clk25MHz;
    logic              reset;
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_out;
    logic              bus_master_ack;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_valid;
    logic              busy;
    logic              timeout_err;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_out;
    logic        exp_terr;

    vga_bus_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk25MHz       (clk25MHz),
        .reset          (reset),
        .bus_req        (bus_req),
        .bus_addr       (bus_addr),
        .bus_out        (bus_out),
        .bus_master_ack (bus_master_ack),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_valid      (mem_valid),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    initial clk25MHz = 1'b0;
    always #20 clk25MHz = ~clk25MHz;

    task automatic tick();
        @(posedge clk25MHz);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus_req = 1'b1; bus_addr = 24'h00ABCD;
        mem_valid = 1'b1; mem_rdata = 32'h12345678;
        tick(); tick();
        n_vec++; if (bus_out !== 32'h0) begin n_err++; $display("FAIL rst_bus_out: got %h want 0", bus_out); end
        n_vec++; if (bus_master_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", bus_master_ack); end
        n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
        n_vec++; if (mem_addr !== 24'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
        bus_req = 1'b0; mem_valid = 1'b0;
        @(negedge clk25MHz);
        reset = 1'b1;
        exp_out = 32'h0; exp_terr = 1'b0;
        tick();
        n_vec++; if (busy !== 1'b0 || mem_rd !== 1'b0) begin n_err++; $display("FAIL rst_idle: got busy=%b rd=%b want 0 0", busy, mem_rd); end
    endtask

    task automatic test_basic();
        bus_req = 1'b1; bus_addr = 24'h000100;
        tick();
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 24'h000100) begin n_err++; $display("FAIL basic_rd: got rd=%b addr=%h want 1 000100", mem_rd, mem_addr); end
        n_vec++; if (busy !== 1'b1 || bus_master_ack !== 1'b0) begin n_err++; $display("FAIL basic_busy: got busy=%b ack=%b want 1 0", busy, bus_master_ack); end
        mem_valid = 1'b1; mem_rdata = 32'h0000ABCD; bus_addr = 24'h0F0F0F;
        tick();
        exp_out = 32'h0000ABCD;
        n_vec++; if (bus_master_ack !== 1'b1 || bus_out !== exp_out) begin n_err++; $display("FAIL basic_ack: got ack=%b out=%h want 1 %h", bus_master_ack, bus_out, exp_out); end
        n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL basic_rd_pulse: got %b want 0", mem_rd); end
        mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_addr = 24'($urandom);
            tick();
            n_vec++; if (bus_master_ack !== 1'b1 || bus_out !== exp_out || mem_addr !== 24'h000100) begin
                n_err++; $display("FAIL basic_hold: got ack=%b out=%h addr=%h want 1 %h 000100", bus_master_ack, bus_out, mem_addr, exp_out);
            end
        end
        bus_req = 1'b0;
        tick();
        n_vec++; if (bus_master_ack !== 1'b0 || busy !== 1'b0 || bus_out !== exp_out) begin
            n_err++; $display("FAIL basic_release: got ack=%b busy=%b out=%h want 0 0 %h", bus_master_ack, busy, bus_out, exp_out);
        end
    endtask

    task automatic test_abort();
        tick();
        bus_req = 1'b1; bus_addr = 24'h000200;
        tick();
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 24'h000200) begin n_err++; $display("FAIL abort_rd: got rd=%b addr=%h want 1 000200", mem_rd, mem_addr); end
        bus_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (bus_master_ack !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL abort_wait: got ack=%b busy=%b want 0 1", bus_master_ack, busy); end
        end
        mem_valid = 1'b1; mem_rdata = 32'hFFFF5432;
        tick();
        mem_valid = 1'b0;
        n_vec++; if (bus_master_ack !== 1'b0 || busy !== 1'b0 || bus_out !== exp_out) begin
            n_err++; $display("FAIL abort_discard: got ack=%b busy=%b out=%h want 0 0 %h", bus_master_ack, busy, bus_out, exp_out);
        end
        tick();
        n_vec++; if (bus_master_ack !== 1'b0 || bus_out !== exp_out) begin n_err++; $display("FAIL abort_after: got ack=%b out=%h want 0 %h", bus_master_ack, bus_out, exp_out); end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] addrs [2];
        int rd_pulses;
        addrs[0] = 24'h000001; addrs[1] = 24'h000002;
        rd_pulses = 0;
        bus_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus_addr = addrs[k];
            tick();
            if (mem_rd === 1'b1) rd_pulses++;
            n_vec++; if (mem_rd !== 1'b1 || mem_addr !== addrs[k]) begin n_err++; $display("FAIL b2b_rd%0d: got rd=%b addr=%h want 1 %h", k, mem_rd, mem_addr, addrs[k]); end
            mem_valid = 1'b1; mem_rdata = 32'hB0B0_0000 + 32'(k);
            tick();
            mem_valid = 1'b0; exp_out = 32'hB0B0_0000 + 32'(k);
            if (mem_rd === 1'b1) rd_pulses++;
            n_vec++; if (bus_master_ack !== 1'b1 || bus_out !== exp_out) begin n_err++; $display("FAIL b2b_ack%0d: got ack=%b out=%h want 1 %h", k, bus_master_ack, bus_out, exp_out); end
            bus_req = 1'b0;
            tick();
            if (mem_rd === 1'b1) rd_pulses++;
            n_vec++; if (bus_master_ack !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin
                n_err++; $display("FAIL b2b_gap%0d: got ack=%b busy=%b rd=%b want 0 0 0", k, bus_master_ack, busy, mem_rd);
            end
            bus_req = 1'b1;
        end
        bus_req = 1'b0;
        n_vec++; if (rd_pulses != 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", rd_pulses); end
    endtask

    task automatic test_timeout();
        tick();
        bus_req = 1'b1; bus_addr = 24'h000300;
        tick();
`ifdef VGA_RESP_TIMEOUT_EN
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            n_vec++; if (bus_master_ack !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL to_early%0d: got ack=%b terr=%b want 0 0", i, bus_master_ack, timeout_err); end
        end
        tick();
        exp_out = 32'hDEADBEEF; exp_terr = 1'b1;
        n_vec++; if (bus_master_ack !== 1'b1 || bus_out !== exp_out || timeout_err !== 1'b1) begin
            n_err++; $display("FAIL to_fire: got ack=%b out=%h terr=%b want 1 %h 1", bus_master_ack, bus_out, timeout_err, exp_out);
        end
`else
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            tick();
            n_vec++; if (bus_master_ack !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
                n_err++; $display("FAIL to_wait%0d: got ack=%b busy=%b terr=%b want 0 1 0", i, bus_master_ack, busy, timeout_err);
            end
        end
        mem_valid = 1'b1; mem_rdata = 32'h600DF00D;
        tick();
        mem_valid = 1'b0; exp_out = 32'h600DF00D;
        n_vec++; if (bus_master_ack !== 1'b1 || bus_out !== exp_out) begin n_err++; $display("FAIL to_late: got ack=%b out=%h want 1 %h", bus_master_ack, bus_out, exp_out); end
`endif
        bus_req = 1'b0;
        tick();
        n_vec++; if (bus_master_ack !== 1'b0 || timeout_err !== exp_terr) begin
            n_err++; $display("FAIL to_sticky: got ack=%b terr=%b want 0 %b", bus_master_ack, timeout_err, exp_terr);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [ADDR_W-1:0] a;
            logic [31:0]       d;
            int                lat, gap, hold;
            bit                abrt;
            a = ADDR_W'($urandom); d = $urandom;
            abrt = ($urandom_range(0, 3) == 0);
            lat  = abrt ? $urandom_range(1, 5) : $urandom_range(0, 5);
            gap  = $urandom_range(0, 3);
            hold = $urandom_range(0, 3);
            bus_req = 1'b0;
            for (int g = 0; g < gap; g++) begin
                mem_valid = 1'($urandom); mem_rdata = $urandom;
                tick();
                n_vec++; if (bus_master_ack !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b0 || bus_out !== exp_out) begin
                    n_err++; $display("FAIL rnd_idle t%0d: got ack=%b rd=%b busy=%b out=%h want 0 0 0 %h", t, bus_master_ack, mem_rd, busy, bus_out, exp_out);
                end
            end
            mem_valid = 1'b0; bus_req = 1'b1; bus_addr = a;
            tick();
            n_vec++; if (mem_rd !== 1'b1 || mem_addr !== a || busy !== 1'b1) begin
                n_err++; $display("FAIL rnd_req t%0d: got rd=%b addr=%h busy=%b want 1 %h 1", t, mem_rd, mem_addr, busy, a);
            end
            if (abrt) bus_req = 1'b0;
            for (int w = 0; w < lat; w++) begin
                bus_addr = ADDR_W'($urandom);
                tick();
                n_vec++; if (bus_master_ack !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b1 || mem_addr !== a) begin
                    n_err++; $display("FAIL rnd_wait t%0d: got ack=%b rd=%b busy=%b addr=%h want 0 0 1 %h", t, bus_master_ack, mem_rd, busy, mem_addr, a);
                end
            end
            mem_valid = 1'b1; mem_rdata = d;
            tick();
            mem_valid = 1'b0;
            if (abrt) begin
                n_vec++; if (bus_master_ack !== 1'b0 || busy !== 1'b0 || bus_out !== exp_out) begin
                    n_err++; $display("FAIL rnd_abort t%0d: got ack=%b busy=%b out=%h want 0 0 %h", t, bus_master_ack, busy, bus_out, exp_out);
                end
            end else begin
                exp_out = d;
                n_vec++; if (bus_master_ack !== 1'b1 || bus_out !== exp_out) begin
                    n_err++; $display("FAIL rnd_ack t%0d: got ack=%b out=%h want 1 %h", t, bus_master_ack, bus_out, exp_out);
                end
                for (int h = 0; h < hold; h++) begin
                    mem_valid = 1'($urandom); mem_rdata = $urandom;
                    tick();
                    n_vec++; if (bus_master_ack !== 1'b1 || bus_out !== exp_out) begin
                        n_err++; $display("FAIL rnd_hold t%0d: got ack=%b out=%h want 1 %h", t, bus_master_ack, bus_out, exp_out);
                    end
                end
                mem_valid = 1'b0; bus_req = 1'b0;
                tick();
                n_vec++; if (bus_master_ack !== 1'b0 || busy !== 1'b0 || timeout_err !== exp_terr) begin
                    n_err++; $display("FAIL rnd_rel t%0d: got ack=%b busy=%b terr=%b want 0 0 %b", t, bus_master_ack, busy, timeout_err, exp_terr);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        bus_req = 1'b1; bus_addr = 24'h000777;
        tick();
        mem_valid = 1'b1; mem_rdata = 32'hCAFE0001;
        tick();
        mem_valid = 1'b0;
        n_vec++; if (bus_master_ack !== 1'b1) begin n_err++; $display("FAIL mid_pre: got ack=%b want 1", bus_master_ack); end
        #5;
        reset = 1'b0;
        #1;
        exp_out = 32'h0; exp_terr = 1'b0;
        n_vec++; if (bus_master_ack !== 1'b0 || bus_out !== exp_out || busy !== 1'b0) begin
            n_err++; $display("FAIL mid_async: got ack=%b out=%h busy=%b want 0 0 0", bus_master_ack, bus_out, busy);
        end
        n_vec++; if (mem_addr !== 24'h0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL mid_clr: got addr=%h terr=%b want 0 0", mem_addr, timeout_err); end
        @(negedge clk25MHz);
        reset = 1'b1; bus_req = 1'b1; bus_addr = 24'h000888;
        tick();
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 24'h000888) begin n_err++; $display("FAIL mid_first: got rd=%b addr=%h want 1 000888", mem_rd, mem_addr); end
        mem_valid = 1'b1; mem_rdata = 32'h5A5A5A5A;
        tick();
        mem_valid = 1'b0; bus_req = 1'b0; exp_out = 32'h5A5A5A5A;
        n_vec++; if (bus_master_ack !== 1'b1 || bus_out !== exp_out) begin n_err++; $display("FAIL mid_ack: got ack=%b out=%h want 1 %h", bus_master_ack, bus_out, exp_out); end
        tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        exp_out = 32'h0; exp_terr = 1'b0;
        reset = 1'b0; bus_req = 1'b0; bus_addr = '0; mem_rdata = '0; mem_valid = 1'b0;
        test_reset();
        test_basic();
        test_abort();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
